// File: rtl/op_stream_decoder_if.sv
// Op-word bus between the op deserializer and the stream decoder, plus the
// decoded event/state outputs consumed by the audio FIFO and keyboard LED logic.
interface op_stream_decoder_if #(
   parameter int unsigned OP_WIDTH  = 16,
   parameter int unsigned CNT_WIDTH = 16
);
   logic [OP_WIDTH-1:0]  op;
   logic                 op_valid;
   logic                 power_on_r1;
   logic                 kbd_led_update;
   logic                 audio_start;
   logic                 audio_stop;
   logic                 sample_valid;
   logic [OP_WIDTH-9:0]  sample_data;
   logic                 orphan_sample;
   logic                 audio_active;
   logic                 rate_44k;
   logic [CNT_WIDTH-1:0] sample_count;
   logic                 bus_reset;

   // Op source side
   modport master (
      output op, op_valid,
      input  power_on_r1, kbd_led_update, audio_start, audio_stop,
             sample_valid, sample_data, orphan_sample, audio_active,
             rate_44k, sample_count, bus_reset
   );

   // Decoder side
   modport slave (
      input  op, op_valid,
      output power_on_r1, kbd_led_update, audio_start, audio_stop,
             sample_valid, sample_data, orphan_sample, audio_active,
             rate_44k, sample_count, bus_reset
   );
endinterface

// File: rtl/op_stream_decoder.sv
// Registered op-word decoder: control pulses, audio stream FSM (IDLE/ACTIVE),
// sample counting and all-ones bus-reset detection.
// Optional feature macro: OPDEC_TIMEOUT_EN enables the inactivity timeout
// and the audio_stop pulse; without it audio_stop is tied low.
module op_stream_decoder #(
   parameter int unsigned OP_WIDTH       = 16,
   parameter int unsigned ONES_RUN       = 2,
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input logic                 clk,
   input logic                 reset_n,
   op_stream_decoder_if.slave  bus
);
   localparam int unsigned DATA_W = OP_WIDTH - 8;
   localparam int unsigned RUN_W  = 4;
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ONES_RUN);

   localparam logic [7:0] CMD_KBD    = 8'hc5;
   localparam logic [7:0] CMD_SAMPLE = 8'hc7;
   localparam logic [7:0] CMD_ST22   = 8'h1f;
   localparam logic [7:0] CMD_ST44   = 8'h0f;
   localparam logic [7:0] CMD_ONES   = 8'hff;
   localparam logic [7:0] ARG_PWR    = 8'hef;
   localparam logic [7:0] ARG_LED    = 8'h00;

   // Elaboration-time parameter sanity check
   if (OP_WIDTH < 16 || ONES_RUN < 1 || ONES_RUN > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("op_stream_decoder: illegal parameter value");
   end

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

   state_e               state_q, state_d;
   logic                 power_on_r1_q, power_on_r1_d;
   logic                 kbd_led_update_q, kbd_led_update_d;
   logic                 audio_start_q, audio_start_d;
   logic                 sample_valid_q, sample_valid_d;
   logic                 orphan_sample_q, orphan_sample_d;
   logic [DATA_W-1:0]    sample_data_q, sample_data_d;
   logic                 rate_44k_q, rate_44k_d;
   logic [CNT_WIDTH-1:0] sample_count_q, sample_count_d;
   logic [RUN_W-1:0]     run_q, run_d;
   logic                 bus_reset_q, bus_reset_d;

`ifdef OPDEC_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 audio_stop_q, audio_stop_d;
`endif

   logic [7:0]        cmd;
   logic [7:0]        arg;
   logic [DATA_W-1:0] payload;
   logic              is_ones, is_start, is_sample;

   // Field extraction and op classification
   assign cmd       = bus.op[OP_WIDTH-1 -: 8];
   assign arg       = bus.op[OP_WIDTH-9 -: 8];
   assign payload   = bus.op[OP_WIDTH-9:0];
   assign is_ones   = bus.op_valid && (cmd == CMD_ONES);
   assign is_start  = bus.op_valid && ((cmd == CMD_ST22) || (cmd == CMD_ST44));
   assign is_sample = bus.op_valid && (cmd == CMD_SAMPLE);

   // Next-state: decode, stream FSM, timeout and all-ones run tracking
   always_comb begin
      state_d          = state_q;
      power_on_r1_d    = 1'b0;
      kbd_led_update_d = 1'b0;
      audio_start_d    = 1'b0;
      sample_valid_d   = 1'b0;
      orphan_sample_d  = 1'b0;
      sample_data_d    = sample_data_q;
      rate_44k_d       = rate_44k_q;
      sample_count_d   = sample_count_q;
      run_d            = run_q;
      bus_reset_d      = bus_reset_q;
`ifdef OPDEC_TIMEOUT_EN
      tmo_d            = tmo_q;
      audio_stop_d     = 1'b0;
`endif

      if (bus.op_valid) begin
         if (is_ones) begin
            if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
         end else begin
            run_d       = '0;
            bus_reset_d = 1'b0;
         end
         power_on_r1_d    = (cmd == CMD_KBD) && (arg == ARG_PWR);
         kbd_led_update_d = (cmd == CMD_KBD) && (arg == ARG_LED);
      end

      if (is_start) begin
         state_d        = ST_ACTIVE;
         rate_44k_d     = (cmd == CMD_ST44);
         sample_count_d = '0;
         audio_start_d  = 1'b1;
`ifdef OPDEC_TIMEOUT_EN
         tmo_d          = TMO_LOAD;
`endif
      end else if (is_sample) begin
         if (state_q == ST_ACTIVE) begin
            sample_valid_d = 1'b1;
            sample_data_d  = payload;
            sample_count_d = sample_count_q + CNT_WIDTH'(1);
`ifdef OPDEC_TIMEOUT_EN
            tmo_d          = TMO_LOAD;
`endif
         end else begin
            orphan_sample_d = 1'b1;
         end
      end
`ifdef OPDEC_TIMEOUT_EN
      else if (state_q == ST_ACTIVE) begin
         if (tmo_q == '0) begin
            state_d      = ST_IDLE;
            audio_stop_d = 1'b1;
         end else begin
            tmo_d = tmo_q - TMO_W'(1);
         end
      end
`endif

      // Completed all-ones run overrides any stream activity this cycle
      if (is_ones && (run_d == RUN_MAX)) begin
         bus_reset_d = 1'b1;
         state_d     = ST_IDLE;
`ifdef OPDEC_TIMEOUT_EN
         audio_stop_d = 1'b0;
`endif
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         power_on_r1_q    <= 1'b0;
         kbd_led_update_q <= 1'b0;
         audio_start_q    <= 1'b0;
         sample_valid_q   <= 1'b0;
         orphan_sample_q  <= 1'b0;
         sample_data_q    <= '0;
         rate_44k_q       <= 1'b0;
         sample_count_q   <= '0;
         run_q            <= '0;
         bus_reset_q      <= 1'b0;
`ifdef OPDEC_TIMEOUT_EN
         tmo_q            <= '0;
         audio_stop_q     <= 1'b0;
`endif
      end else begin
         state_q          <= state_d;
         power_on_r1_q    <= power_on_r1_d;
         kbd_led_update_q <= kbd_led_update_d;
         audio_start_q    <= audio_start_d;
         sample_valid_q   <= sample_valid_d;
         orphan_sample_q  <= orphan_sample_d;
         sample_data_q    <= sample_data_d;
         rate_44k_q       <= rate_44k_d;
         sample_count_q   <= sample_count_d;
         run_q            <= run_d;
         bus_reset_q      <= bus_reset_d;
`ifdef OPDEC_TIMEOUT_EN
         tmo_q            <= tmo_d;
         audio_stop_q     <= audio_stop_d;
`endif
      end
   end

   // Output mapping
   assign bus.power_on_r1    = power_on_r1_q;
   assign bus.kbd_led_update = kbd_led_update_q;
   assign bus.audio_start    = audio_start_q;
   assign bus.sample_valid   = sample_valid_q;
   assign bus.orphan_sample  = orphan_sample_q;
   assign bus.sample_data    = sample_data_q;
   assign bus.audio_active   = (state_q == ST_ACTIVE);
   assign bus.rate_44k       = rate_44k_q;
   assign bus.sample_count   = sample_count_q;
   assign bus.bus_reset      = bus_reset_q;
`ifdef OPDEC_TIMEOUT_EN
   assign bus.audio_stop     = audio_stop_q;
`else
   assign bus.audio_stop     = 1'b0;
`endif
endmodule

// File: tb/tb_op_stream_decoder.sv
// Self-checking bench for op_stream_decoder: directed vector table, corner
// sequences, and randomized ops checked against an event-level model.
module tb_op_stream_decoder;
   localparam int unsigned OP_WIDTH  = 16;
   localparam int unsigned ONES_RUN  = 2;
   localparam int unsigned CNT_WIDTH = 4;
   localparam int unsigned TMO       = 8;
`ifdef OPDEC_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   op_stream_decoder_if #(.OP_WIDTH(OP_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

   op_stream_decoder #(
      .OP_WIDTH(OP_WIDTH), .ONES_RUN(ONES_RUN),
      .CNT_WIDTH(CNT_WIDTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // Behavioural model state (event level, timeout by edge distance)
   int       m_edge = 0;
   int       m_last_kick = 0;
   int       m_run = 0;
   int       m_count = 0;
   bit       m_active, m_rate, m_bus_reset;
   bit       m_pwr, m_kbd, m_start, m_stop, m_sv, m_orphan;
   bit [7:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic v, input logic [15:0] o, input logic r);
      bit [7:0] c, a;
      bit kicked;
      c = o[15:8];
      a = o[7:0];
      {m_pwr, m_kbd, m_start, m_stop, m_sv, m_orphan} = '0;
      m_edge++;
      if (!r) begin
         m_active = 0; m_rate = 0; m_bus_reset = 0; m_data = '0;
         m_run = 0; m_count = 0;
         return;
      end
      kicked = 0;
      if (v) begin
         if (c == 8'hff) m_run = (m_run < ONES_RUN) ? m_run + 1 : m_run;
         else begin m_run = 0; m_bus_reset = 0; end
         m_pwr = (c == 8'hc5) && (a == 8'hef);
         m_kbd = (c == 8'hc5) && (a == 8'h00);
         if (c == 8'h0f || c == 8'h1f) begin
            m_active = 1; m_rate = (c == 8'h0f); m_count = 0;
            m_start = 1; kicked = 1;
         end else if (c == 8'hc7) begin
            if (m_active) begin
               m_sv = 1; m_data = a; m_count = (m_count + 1) % (1 << CNT_WIDTH);
               kicked = 1;
            end else m_orphan = 1;
         end
      end
      if (kicked) m_last_kick = m_edge;
      else if (TO_EN && m_active && (m_edge - m_last_kick >= int'(TMO))) begin
         m_active = 0; m_stop = 1;
      end
      if (v && c == 8'hff && m_run == ONES_RUN) begin
         m_bus_reset = 1; m_active = 0; m_stop = 0;
      end
   endtask

   task automatic check_model();
      chk("m_power_on_r1",    32'(bus.power_on_r1),    32'(m_pwr));
      chk("m_kbd_led_update", 32'(bus.kbd_led_update), 32'(m_kbd));
      chk("m_audio_start",    32'(bus.audio_start),    32'(m_start));
      chk("m_audio_stop",     32'(bus.audio_stop),     32'(m_stop));
      chk("m_sample_valid",   32'(bus.sample_valid),   32'(m_sv));
      chk("m_orphan_sample",  32'(bus.orphan_sample),  32'(m_orphan));
      chk("m_sample_data",    32'(bus.sample_data),    32'(m_data));
      chk("m_audio_active",   32'(bus.audio_active),   32'(m_active));
      chk("m_rate_44k",       32'(bus.rate_44k),       32'(m_rate));
      chk("m_sample_count",   32'(bus.sample_count),   32'(m_count));
      chk("m_bus_reset",      32'(bus.bus_reset),      32'(m_bus_reset));
   endtask

   // One clock: drive, edge, advance model, sample #1 later
   task automatic step(input logic [15:0] o, input logic v, input logic r);
      bus.op = o;
      bus.op_valid = v;
      reset_n = r;
      @(posedge clk);
      model_step(v, o, r);
      #1;
      check_model();
   endtask

   typedef struct {
      logic [15:0] op;
      logic        valid;
      logic        pwr, kbd, start, sv, orphan, active, rate, br;
      logic [3:0]  count;
      logic [7:0]  data;
   } vec_t;

   vec_t vt[19];
   int   stops;

   initial begin
      bus.op = '0;
      bus.op_valid = 1'b0;

      // Reset state
      step(16'h0000, 1'b0, 1'b0);
      step(16'hc5ef, 1'b1, 1'b0);

      //          op        v  pwr kbd st sv orp act rate br cnt data
      vt[0]  = '{16'hc5ef, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00};
      vt[1]  = '{16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00};
      vt[2]  = '{16'hc500, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00};
      vt[3]  = '{16'hc501, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h00};
      vt[4]  = '{16'h0f00, 1, 0, 0, 1, 0, 0, 1, 1, 0, 4'd0, 8'h00};
      vt[5]  = '{16'hc712, 1, 0, 0, 0, 1, 0, 1, 1, 0, 4'd1, 8'h12};
      vt[6]  = '{16'hc734, 1, 0, 0, 0, 1, 0, 1, 1, 0, 4'd2, 8'h34};
      vt[7]  = '{16'hc756, 1, 0, 0, 0, 1, 0, 1, 1, 0, 4'd3, 8'h56};
      vt[8]  = '{16'h1f00, 1, 0, 0, 1, 0, 0, 1, 0, 0, 4'd0, 8'h56};
      vt[9]  = '{16'hffff, 1, 0, 0, 0, 0, 0, 1, 0, 0, 4'd0, 8'h56};
      vt[10] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd0, 8'h56};
      vt[11] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd0, 8'h56};
      vt[12] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd0, 8'h56};
      vt[13] = '{16'hffff, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 8'h56};
      vt[14] = '{16'hc500, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h56};
      vt[15] = '{16'hc7aa, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd0, 8'h56};
      vt[16] = '{16'hffff, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h56};
      vt[17] = '{16'hc500, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 8'h56};
      vt[18] = '{16'hffff, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 8'h56};

      for (int i = 0; i < 19; i++) begin
         step(vt[i].op, vt[i].valid, 1'b1);
         chk($sformatf("v%0d_power", i),  32'(bus.power_on_r1),    32'(vt[i].pwr));
         chk($sformatf("v%0d_kbd", i),    32'(bus.kbd_led_update), 32'(vt[i].kbd));
         chk($sformatf("v%0d_start", i),  32'(bus.audio_start),    32'(vt[i].start));
         chk($sformatf("v%0d_sv", i),     32'(bus.sample_valid),   32'(vt[i].sv));
         chk($sformatf("v%0d_orphan", i), 32'(bus.orphan_sample),  32'(vt[i].orphan));
         chk($sformatf("v%0d_active", i), 32'(bus.audio_active),   32'(vt[i].active));
         chk($sformatf("v%0d_rate", i),   32'(bus.rate_44k),       32'(vt[i].rate));
         chk($sformatf("v%0d_busrst", i), 32'(bus.bus_reset),      32'(vt[i].br));
         chk($sformatf("v%0d_count", i),  32'(bus.sample_count),   32'(vt[i].count));
         chk($sformatf("v%0d_data", i),   32'(bus.sample_data),    32'(vt[i].data));
      end

      // Timeout: stop exactly TMO cycles after start
      step(16'h1f00, 1'b1, 1'b1);
      for (int k = 1; k <= int'(TMO) + 1; k++) begin
         step(16'h0000, 1'b0, 1'b1);
         chk($sformatf("to_stop_k%0d", k), 32'(bus.audio_stop), 32'(TO_EN && k == int'(TMO)));
         chk($sformatf("to_active_k%0d", k), 32'(bus.audio_active), 32'(!(TO_EN && k >= int'(TMO))));
      end

      // Sample on the firing cycle wins and reloads the timeout
      step(16'h0f00, 1'b1, 1'b1);
      for (int k = 1; k < int'(TMO); k++) step(16'h0000, 1'b0, 1'b1);
      step(16'hc799, 1'b1, 1'b1);
      chk("race_stop", 32'(bus.audio_stop), 32'd0);
      chk("race_sv", 32'(bus.sample_valid), 32'd1);
      for (int k = 1; k <= int'(TMO); k++) begin
         step(16'h0000, 1'b0, 1'b1);
         chk($sformatf("reload_stop_k%0d", k), 32'(bus.audio_stop), 32'(TO_EN && k == int'(TMO)));
      end

      // Long idle: stream stays active only without the timeout
      step(16'h0f00, 1'b1, 1'b1);
      stops = 0;
      for (int k = 0; k < 1000; k++) begin
         step(16'h0000, 1'b0, 1'b1);
         if (bus.audio_stop) stops++;
      end
      chk("idle1000_active", 32'(bus.audio_active), 32'(!TO_EN));
      chk("idle1000_stops", 32'(stops), 32'(TO_EN ? 1 : 0));

      // Sample counter wraps modulo 2^CNT_WIDTH
      step(16'h1f00, 1'b1, 1'b1);
      for (int k = 0; k < 17; k++) step(16'hc700 | 16'(k), 1'b1, 1'b1);
      chk("wrap_count", 32'(bus.sample_count), 32'd1);
      chk("wrap_data", 32'(bus.sample_data), 32'h10);

      // Reset mid-stream returns everything to reset values, no stop pulse
      step(16'hc7ab, 1'b1, 1'b1);
      step(16'hc5ef, 1'b1, 1'b0);
      chk("rst_active", 32'(bus.audio_active), 32'd0);
      chk("rst_count", 32'(bus.sample_count), 32'd0);
      chk("rst_data", 32'(bus.sample_data), 32'd0);
      chk("rst_rate", 32'(bus.rate_44k), 32'd0);
      chk("rst_stop", 32'(bus.audio_stop), 32'd0);
      chk("rst_power", 32'(bus.power_on_r1), 32'd0);

      // Randomized ops checked by the model every cycle
      for (int n = 0; n < 4000; n++) begin
         logic [7:0] c, a;
         logic v, r;
         case ($urandom_range(0, 6))
            0: c = 8'hc5;
            1: c = 8'h0f;
            2: c = 8'h1f;
            3, 4: c = 8'hc7;
            5: c = 8'hff;
            default: c = 8'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: a = 8'hef;
            1: a = 8'h00;
            default: a = 8'($urandom);
         endcase
         v = ((n / 200) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1);
         r = ($urandom_range(0, 199) != 0);
         step({c, a}, v, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
